axi_stream_serializer: RTL and testbench
========================================

AXI_STREAM_SERIALIZER -- requirements
Module: axi_stream_serializer

Interface
REQ-001 SHALL have parameter BW, default 2: number of 32-bit lanes per input beat (BW >= 1).
REQ-002 SHALL have parameter PKT_BEATS, default 4: input beats per packet, used for out_last generation (PKT_BEATS >= 1).
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: the upstream wide beat is valid.
REQ-006 SHALL have port in_stream  input  BW x 32 (packed [BW-1:0][31:0]): the wide beat; lane 0 is the least significant.
REQ-007 SHALL have port in_ready  output  1: the block accepts a wide beat.
REQ-008 SHALL have port out_valid  output  1: out_data holds a valid lane.
REQ-009 SHALL have port out_ready  input  1: the downstream consumer accepts the lane.
REQ-010 SHALL have port out_data  output  32: the current serialized lane.
REQ-011 SHALL have port out_last  output  1: the final lane of the final beat of a packet.

Function
REQ-012 SHALL treat an input transfer as in_valid && in_ready, and an output transfer as out_valid && out_ready, both sampled at the clock edge.
REQ-013 SHALL implement a two-state FSM: EMPTY (no held beat) and SEND (beat held, emitting lanes).
REQ-014 SHALL, on an input transfer in EMPTY, register in_stream into the hold register, clear lane_idx to 0 and enter SEND.
REQ-015 SHALL, in SEND, drive out_valid=1 and out_data=hold[lane_idx], emitting lane 0 first and BW-1 last.
REQ-016 SHALL, in EMPTY, drive out_valid=0, out_last=0 and out_data=0.
REQ-017 SHALL increment lane_idx on an output transfer when lane_idx < BW-1.
REQ-018 SHALL, on an output transfer with lane_idx == BW-1, take one of two actions: if an input transfer occurs in the same cycle, load the new beat, set lane_idx=0 and stay in SEND; otherwise return to EMPTY.
REQ-019 SHALL hold out_data, out_valid and out_last stable while out_valid=1 && out_ready=0.
REQ-020 SHALL keep beat_cnt (0..PKT_BEATS-1), which increments on the output transfer of lane BW-1 and wraps to 0 after PKT_BEATS-1.
REQ-021 SHALL drive out_last = out_valid && lane_idx==BW-1 && beat_cnt==PKT_BEATS-1.
REQ-022 SHALL, when BW == 1, treat every lane as the last lane, giving one output transfer per input beat.
REQ-023 SHALL sustain one output transfer per cycle while in_valid and out_ready are continuously high: BW output lanes per input beat, with no bubbles.
REQ-024 SHALL have a first-lane latency of one cycle: out_valid rises in the cycle after the input transfer.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, force state=EMPTY, lane_idx=0, beat_cnt=0, hold register=0, out_valid=0, out_last=0 and out_data=0.
REQ-026 SHALL drive in_ready=0 while rst=1, and SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-027 SHALL, if rst asserts mid-packet, discard the held beat and any partial packet count; the first beat after reset starts a new packet.

Configuration
REQ-028 SHALL, without SERIALIZER_SKID_EN defined, drive in_ready = (state==EMPTY) || (lane_idx==BW-1 && out_ready), a combinational path from out_ready.
REQ-029 SHALL, with SERIALIZER_SKID_EN defined, add one BW x 32 skid register with a valid flag; in_ready SHALL be a registered output equal to !skid_valid, with no combinational path from out_ready.
REQ-030 SHALL, with SERIALIZER_SKID_EN defined, route a beat accepted while the hold register is busy and not being freed into the skid register, and load it into the hold register at the next last-lane transfer; ordering and throughput SHALL match REQ-018 and REQ-023.

Verification
REQ-031 Bench SHALL cover single beat: BW=2, in_stream={32'hBBBB0002, 32'hAAAA0001} with out_ready=1 -> out_data 0xAAAA0001 then 0xBBBB0002 on consecutive cycles, out_valid then low.
REQ-032 Bench SHALL cover back-to-back: 4 beats with in_valid=1 and out_ready=1 throughout -> 8 consecutive lane transfers with no gap; out_last=1 only on lane 8.
REQ-033 Bench SHALL cover backpressure: out_ready=0 for 3 cycles mid-lane -> out_data and out_last stable, no lane lost or duplicated, in_ready=0 without SERIALIZER_SKID_EN.
REQ-034 Bench SHALL cover wrap: 9 beats with PKT_BEATS=4 -> out_last on beats 4 and 8, beat_cnt=1 after beat 9.
REQ-035 Bench SHALL cover mid-operation reset: rst pulsed after lane 0 of beat 2 -> outputs 0 immediately, next beat emitted from lane 0, out_last after 4 further beats.
REQ-036 Bench SHALL cover BW=1 with SERIALIZER_SKID_EN defined: random in_valid/out_ready -> output sequence equals input sequence, in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/axi_stream_serializer_if.sv
// Handshake bundle for axi_stream_serializer: BW x 32-bit beats in, 32-bit lanes out.
// slave is the serializer's view; master is the driving/consuming environment.
interface axi_stream_serializer_if #(
    parameter int BW = 2
);
    logic                in_valid;
    logic [BW-1:0][31:0] in_stream;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic                out_last;

    modport slave (
        input  in_valid, in_stream, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_stream, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/axi_stream_serializer.sv
// Serializes BW x 32-bit beats into 32-bit lanes (lane 0 first), flagging packet ends.
// Define SERIALIZER_SKID_EN to break the out_ready -> in_ready path with a one-beat skid buffer.
module axi_stream_serializer #(
    parameter int BW        = 2,
    parameter int PKT_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_stream_serializer_if.slave s
);
    localparam int LW = (BW > 1) ? $clog2(BW) : 1;
    localparam int CW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(BW - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_BEATS - 1);

    typedef enum logic {EMPTY, SEND} state_t;

    state_t              state, nxt_state;
    logic [LW-1:0]       lane_idx, nxt_lane;
    logic [CW-1:0]       beat_cnt, nxt_cnt;
    logic [BW-1:0][31:0] hold, nxt_hold, new_beat;
    logic [31:0]         nxt_data;
    logic                in_xfer, out_xfer, last_lane, take_new;

    assign in_xfer   = s.in_valid && s.in_ready;
    assign out_xfer  = s.out_valid && s.out_ready;
    assign last_lane = (lane_idx == LAST_LANE);

`ifdef SERIALIZER_SKID_EN
    logic                skid_valid;
    logic [BW-1:0][31:0] skid_data;
    logic                hold_free;

    assign hold_free  = (state == EMPTY) || (out_xfer && last_lane);
    // in_ready depends only on state, so a stalled consumer cannot ripple upstream
    assign s.in_ready = !rst && !skid_valid;
    assign take_new   = skid_valid || in_xfer;
    assign new_beat   = skid_valid ? skid_data : s.in_stream;
`else
    assign s.in_ready = !rst && ((state == EMPTY) || (last_lane && s.out_ready));
    assign take_new   = in_xfer;
    assign new_beat   = s.in_stream;
`endif

    always_comb begin
        nxt_state = state;
        nxt_lane  = lane_idx;
        nxt_cnt   = beat_cnt;
        nxt_hold  = hold;
        if (state == EMPTY) begin
            if (take_new) begin
                nxt_state = SEND;
                nxt_lane  = '0;
                nxt_hold  = new_beat;
            end
        end else if (out_xfer) begin
            if (!last_lane) begin
                nxt_lane = lane_idx + 1'b1;
            end else begin
                nxt_cnt = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
                if (take_new) begin
                    nxt_lane = '0;
                    nxt_hold = new_beat;
                end else begin
                    nxt_state = EMPTY;
                end
            end
        end
    end

    always_comb begin
        nxt_data = '0;
        for (int i = 0; i < BW; i++)
            if (nxt_lane == LW'(i)) nxt_data = nxt_hold[i];
    end

    // Outputs are registered from next-state values, so they hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            lane_idx    <= '0;
            beat_cnt    <= '0;
            hold        <= '0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_last  <= 1'b0;
`ifdef SERIALIZER_SKID_EN
            skid_valid  <= 1'b0;
            skid_data   <= '0;
`endif
        end else begin
            state       <= nxt_state;
            lane_idx    <= nxt_lane;
            beat_cnt    <= nxt_cnt;
            hold        <= nxt_hold;
            s.out_valid <= (nxt_state == SEND);
            s.out_data  <= (nxt_state == SEND) ? nxt_data : '0;
            s.out_last  <= (nxt_state == SEND) && (nxt_lane == LAST_LANE) && (nxt_cnt == LAST_BEAT);
`ifdef SERIALIZER_SKID_EN
            if (skid_valid && hold_free) begin
                skid_valid <= 1'b0;
            end else if (in_xfer && !hold_free) begin
                skid_valid <= 1'b1;
                skid_data  <= s.in_stream;
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi_stream_serializer.sv
// Self-checking bench: BW=2/PKT_BEATS=4 directed + random, BW=1/PKT_BEATS=3 random,
// both against a lane-queue model of the serializer.
module tb_axi_stream_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_stream_serializer_if #(.BW(2)) if0 ();
    axi_stream_serializer_if #(.BW(1)) if1 ();

    axi_stream_serializer #(.BW(2), .PKT_BEATS(4)) u0 (.clk(clk), .rst(rst), .s(if0.slave));
    axi_stream_serializer #(.BW(1), .PKT_BEATS(3)) u1 (.clk(clk), .rst(rst), .s(if1.slave));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        l;
    } lane_t;

    // ---------------- DUT0 model: expected lanes in order ----------------
    lane_t             q0[$];
    int                ln0 = 0;
    logic [1:0][31:0]  src0[$];
    int                or_mode = 0;   // 0: ready high, 1: random, 2: main drives
    bit                rnd_in  = 0;
    int                cyc = 0, xfer_cnt = 0, first_cyc = -1, last_cyc = -1;
    logic [31:0]       first_data = '0;
    int                last_at[$];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (if0.out_valid && if0.out_ready) begin
            xfer_cnt++;
            if (xfer_cnt == 1) begin
                first_cyc  = cyc;
                first_data = if0.out_data;
            end
            last_cyc = cyc;
            if (if0.out_last) last_at.push_back(xfer_cnt);
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (if0.in_valid && if0.in_ready) begin
            for (int i = 0; i < 2; i++) begin
                q0.push_back('{if0.in_stream[i], (ln0 % 8) == 7});
                ln0++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            q0.delete();
            ln0 = 0;
            chk("u0_rst_valid", if0.out_valid, 0);
            chk("u0_rst_data", if0.out_data, 0);
        end else begin
            chk("u0_valid", if0.out_valid, q0.size() != 0);
            if (q0.size() != 0) begin
                chk("u0_data", if0.out_data, q0[0].d);
                chk("u0_last", if0.out_last, q0[0].l);
            end else begin
                chk("u0_idle_data", if0.out_data, 0);
                chk("u0_idle_last", if0.out_last, 0);
            end
        end
    end

    // DUT0 driver: AXI-legal, in_stream held until accepted
    initial begin
        bit acc;
        if0.in_valid  = 1'b0;
        if0.in_stream = '0;
        if0.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            acc = if0.in_valid && if0.in_ready;
            #1;
            if (acc && src0.size() > 0) void'(src0.pop_front());
            if (rst) begin
                if0.in_valid = 1'b0;
            end else if (!if0.in_valid || acc) begin
                if (src0.size() > 0 && (!rnd_in || $urandom_range(0, 3) != 0)) begin
                    if0.in_valid  = 1'b1;
                    if0.in_stream = src0[0];
                end else begin
                    if0.in_valid = 1'b0;
                end
            end
            if (or_mode == 0) if0.out_ready = 1'b1;
            else if (or_mode == 1) if0.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- DUT1 (BW=1, PKT_BEATS=3) random run ----------------
    lane_t q1[$];
    int    ln1 = 0;

    initial begin
        bit   acc1, oxf1;
        logic r;
        if1.in_valid  = 1'b0;
        if1.in_stream = '0;
        if1.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            acc1 = if1.in_valid && if1.in_ready;
            oxf1 = if1.out_valid && if1.out_ready;
            if (rst) begin
                q1.delete();
                ln1 = 0;
            end else begin
                if (oxf1 && q1.size() > 0) void'(q1.pop_front());
                if (acc1) begin
                    q1.push_back('{if1.in_stream[0], (ln1 % 3) == 2});
                    ln1++;
                end
            end
            #1;
            if (!if1.in_valid || acc1) begin
                if1.in_valid     = $urandom_range(0, 1) != 0;
                if1.in_stream[0] = $urandom;
            end
            if1.out_ready = $urandom_range(0, 1) != 0;
            #2;
`ifdef SERIALIZER_SKID_EN
            r = if1.in_ready;
            if1.out_ready = !if1.out_ready;
            #1;
            chk("u1_ready_no_comb_path", if1.in_ready, r);
`else
            r = !rst && (!if1.out_valid || if1.out_ready);
            chk("u1_ready", if1.in_ready, r);
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("u1_valid", if1.out_valid, q1.size() != 0);
            if (q1.size() != 0) begin
                chk("u1_data", if1.out_data, q1[0].d);
                chk("u1_last", if1.out_last, q1[0].l);
            end else begin
                chk("u1_idle_data", if1.out_data, 0);
            end
        end
    end

    // ---------------- directed sequences on DUT0 ----------------
    task automatic clr_mon();
        xfer_cnt = 0;
        first_cyc = -1;
        last_cyc  = -1;
        last_at.delete();
    endtask

    // Called at #1 after a rising edge
    task automatic do_reset();
        rst = 1'b1;
        src0.delete();
        if0.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", if0.in_ready, 0);
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_out_data", if0.out_data, 0);
        chk("rst_out_last", if0.out_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", if0.in_ready, 1);
        clr_mon();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int t = 0;
        while ((src0.size() != 0 || if0.in_valid || if0.out_valid) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({nm, "_timeout"}, t < budget, 1);
    endtask

    task automatic wait_valid(input string nm);
        int t = 0;
        while (!if0.out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({nm, "_valid_timeout"}, t < 50, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // single beat
        src0.push_back({32'hBBBB0002, 32'hAAAA0001});
        wait_valid("single");
        chk("single_lane0", if0.out_data, 32'hAAAA0001);
        @(posedge clk); #1;
        chk("single_lane1", if0.out_data, 32'hBBBB0002);
        chk("single_last", if0.out_last, 0);
        @(posedge clk); #1;
        chk("single_done_valid", if0.out_valid, 0);
        wait_idle("single", 50);

        // back-to-back: 4 beats, 8 gapless lanes, last only on lane 8
        @(posedge clk); #1;
        do_reset();
        for (int b = 0; b < 4; b++)
            src0.push_back({32'h1000_0000 + 32'(2 * b + 1), 32'h1000_0000 + 32'(2 * b)});
        wait_idle("b2b", 100);
        chk("b2b_xfers", xfer_cnt, 8);
        chk("b2b_span", last_cyc - first_cyc, 7);
        chk("b2b_last_cnt", last_at.size(), 1);
        if (last_at.size() > 0) chk("b2b_last_pos", last_at[0], 8);

        // backpressure: 3 stall cycles on lane 0
        @(posedge clk); #1;
        do_reset();
        or_mode = 2;
        if0.out_ready = 1'b1;
        src0.push_back({32'h2222_0001, 32'h2222_0000});
        src0.push_back({32'h2222_0003, 32'h2222_0002});
        wait_valid("bp");
        if0.out_ready = 1'b0;
        chk("bp_first", if0.out_data, 32'h2222_0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", if0.out_data, 32'h2222_0000);
            chk("bp_hold_valid", if0.out_valid, 1);
            chk("bp_hold_last", if0.out_last, 0);
`ifndef SERIALIZER_SKID_EN
            chk("bp_in_ready", if0.in_ready, 0);
`endif
        end
        if0.out_ready = 1'b1;
        or_mode = 0;
        wait_idle("bp", 100);
        chk("bp_xfers", xfer_cnt, 4);

        // wrap: 9 beats, then 3 more closes the packet started by beat 9
        @(posedge clk); #1;
        do_reset();
        for (int b = 0; b < 9; b++) src0.push_back({32'h3300_0000 + 32'(b), 32'h3000_0000 + 32'(b)});
        wait_idle("wrap", 200);
        chk("wrap_xfers", xfer_cnt, 18);
        chk("wrap_last_cnt", last_at.size(), 2);
        if (last_at.size() == 2) begin
            chk("wrap_last0", last_at[0], 8);
            chk("wrap_last1", last_at[1], 16);
        end
        for (int b = 0; b < 3; b++) src0.push_back({32'h3500_0000 + 32'(b), 32'h3400_0000 + 32'(b)});
        wait_idle("wrap2", 100);
        chk("wrap2_last_cnt", last_at.size(), 3);
        if (last_at.size() == 3) chk("wrap2_last_pos", last_at[2], 24);

        // mid-operation reset after lane 0 of beat 2
        @(posedge clk); #1;
        do_reset();
        src0.push_back({32'h4000_0001, 32'h4000_0000});
        src0.push_back({32'h4000_0003, 32'h4000_0002});
        begin
            int t = 0;
            while (xfer_cnt < 3 && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            chk("midrst_wait_timeout", t < 50, 1);
        end
        do_reset();
        for (int b = 0; b < 4; b++)
            src0.push_back({32'hC0DE_0000 + 32'(2 * b + 1), 32'hC0DE_0000 + 32'(2 * b)});
        wait_idle("midrst", 100);
        chk("midrst_first", first_data, 32'hC0DE_0000);
        chk("midrst_xfers", xfer_cnt, 8);
        chk("midrst_last_cnt", last_at.size(), 1);
        if (last_at.size() > 0) chk("midrst_last_pos", last_at[0], 8);

        // random traffic on both instances
        or_mode = 1;
        rnd_in  = 1'b1;
        for (int b = 0; b < 40; b++) src0.push_back({$urandom, $urandom});
        wait_idle("rand", 2000);
        or_mode = 0;
        rnd_in  = 1'b0;
        repeat (200) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
